// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor datapath.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // In SUB the carry-in is a borrow-in, so the adder sees its complement.
  function automatic logic eff_carry_in(input logic sub, input logic cin);
    return (sub == OP_SUB) ? ~cin : cin;
  endfunction

endpackage

// File: rtl/Full_Adder.sv
// 1-bit full adder cell.
module Full_Adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/addsub_slice.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its top bit
// so the slice holding the MSB can feed signed-overflow detection.
module addsub_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    Full_Adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor resolving one CHUNK-bit slice per stage.
// Unconsumed operand bits shift down with the beat so every stage adds bits
// [CHUNK-1:0] of its record; finished result slices enter sum_done from the
// top, so after the last stage the full result sits in place.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
    logic [WIDTH-1:0] sum_done;
    logic             carry;
    logic             carry_into_msb;
  } stage_t;

  stage_t stg_q [STAGES];
  stage_t stg_d [STAGES];
  logic   adv;

  // One global enable: the whole pipe moves unless the output is held.
  assign adv      = !stg_q[LAST].valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             p_valid;
    logic [WIDTH-1:0] p_a;
    logic [WIDTH-1:0] p_b;
    logic [WIDTH-1:0] p_sum;
    logic             p_carry;
    logic [CHUNK-1:0] s;
    logic             cout;
    logic             c_msb;

    if (k == 0) begin : g_src_in
      assign p_valid = in_valid;
      assign p_a     = A;
      assign p_b     = (sub == OP_SUB) ? ~B : B;
      assign p_sum   = '0;
      assign p_carry = eff_carry_in(sub, Cin);
    end else begin : g_src_prev
      assign p_valid = stg_q[k-1].valid;
      assign p_a     = stg_q[k-1].a_rem;
      assign p_b     = stg_q[k-1].b_rem;
      assign p_sum   = stg_q[k-1].sum_done;
      assign p_carry = stg_q[k-1].carry;
    end

    addsub_slice #(.CHUNK(CHUNK)) u_slice (
      .a        (p_a[CHUNK-1:0]),
      .b        (p_b[CHUNK-1:0]),
      .cin      (p_carry),
      .s        (s),
      .cout     (cout),
      .c_msb_in (c_msb)
    );

    assign stg_d[k] = '{
      valid:          p_valid,
      a_rem:          p_a >> CHUNK,
      b_rem:          p_b >> CHUNK,
      sum_done:       (p_sum >> CHUNK) | (WIDTH'(s) << (WIDTH - CHUNK)),
      carry:          cout,
      carry_into_msb: c_msb
    };
  end

  // Stage registers: cleared by reset, advanced together on adv.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) stg_q[k] <= '0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) stg_q[k] <= stg_d[k];
    end
  end

  assign out_valid = stg_q[LAST].valid;
  assign Sum       = stg_q[LAST].sum_done;
  assign Cout      = stg_q[LAST].carry;
  assign Ovf       = stg_q[LAST].carry ^ stg_q[LAST].carry_into_msb;
  // Gated by valid so a cleared pipe reports Zero=0 rather than "0 == 0".
  assign Zero      = stg_q[LAST].valid && (stg_q[LAST].sum_done == '0);

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub (WIDTH=32, STAGES=4).
module tb_pipelined_addsub;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
  localparam int NVEC   = 10;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;
  logic             Zero;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs [NVEC];

  pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .Ovf       (Ovf),
    .Zero      (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vec(input int i);
    in_valid = 1'b1;
    A        = vecs[i].a;
    B        = vecs[i].b;
    Cin      = vecs[i].cin;
    sub      = vecs[i].sub;
  endtask

  task automatic check_result(input int i);
    chk($sformatf("vec%0d.sum", i),  Sum,         vecs[i].sum);
    chk($sformatf("vec%0d.cout", i), 32'(Cout),   32'(vecs[i].cout));
    chk($sformatf("vec%0d.ovf", i),  32'(Ovf),    32'(vecs[i].ovf));
    chk($sformatf("vec%0d.zero", i), 32'(Zero),   32'(vecs[i].zero));
  endtask

  initial begin
    int lat;
    int got;
    int next_beat;
    int idx;
    int q[$];
    logic accepted;
    logic emitted;

    //            a             b             cin   sub   sum           cout  ovf   zero
    vecs[0] = '{32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[9] = '{32'h1234_5678, 32'h0FED_CBA8, 1'b0, 1'b0, 32'h2222_2220, 1'b0, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    Cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.sum",       Sum,            32'd0);
    chk("rst.cout",      32'(Cout),      32'd0);
    chk("rst.ovf",       32'(Ovf),       32'd0);
    chk("rst.zero",      32'(Zero),      32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    // Single beats: latency must be exactly STAGES edges, then a bubble follows.
    for (int i = 0; i < NVEC; i++) begin
      drive_vec(i);
      lat = 0;
      for (int n = 1; n <= 10; n++) begin
        tick();
        if (n == 1) in_valid = 1'b0;
        if (out_valid) begin
          lat = n;
          break;
        end
      end
      chk($sformatf("vec%0d.latency", i), 32'(lat), 32'(STAGES));
      if (lat != 0) check_result(i);
      tick();
      chk($sformatf("vec%0d.bubble_after", i), 32'(out_valid), 32'd0);
    end

    // Back-to-back stream of the whole table with out_ready held high.
    idx = 0;
    got = 0;
    q.delete();
    for (int c = 0; c < 60 && got < NVEC; c++) begin
      if (idx < NVEC) drive_vec(idx);
      else in_valid = 1'b0;
      #1;
      if (idx < NVEC) chk($sformatf("stream.in_ready%0d", c), 32'(in_ready), 32'd1);
      accepted = in_valid && in_ready;
      emitted  = out_valid && out_ready;
      if (emitted) begin
        if (q.size() == 0) chk("stream.unexpected_out", 32'd1, 32'd0);
        else check_result(q.pop_front());
        got++;
      end
      if (accepted) begin
        q.push_back(idx);
        idx++;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("stream.count", 32'(got), 32'(NVEC));

    // Backpressure: beats A=B=i, out_ready low during cycles 5..8.
    tick();
    tick();
    next_beat = 1;
    got       = 0;
    for (int cyc = 1; cyc <= 60 && got < 6; cyc++) begin
      out_ready = !(cyc >= 5 && cyc <= 8);
      if (next_beat <= 6) begin
        in_valid = 1'b1;
        A        = 32'(next_beat);
        B        = 32'(next_beat);
        Cin      = 1'b0;
        sub      = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc >= 5 && cyc <= 8) begin
        chk($sformatf("bp.in_ready_c%0d", cyc),  32'(in_ready),  32'd0);
        chk($sformatf("bp.out_valid_c%0d", cyc), 32'(out_valid), 32'd1);
        chk($sformatf("bp.hold_sum_c%0d", cyc),  Sum,            32'd2);
      end
      accepted = in_valid && in_ready;
      emitted  = out_valid && out_ready;
      if (emitted) begin
        got++;
        chk($sformatf("bp.sum%0d", got), Sum, 32'(2 * got));
      end
      tick();
      if (accepted) next_beat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp.count", 32'(got), 32'd6);
    for (int n = 0; n < 6; n++) begin
      tick();
      if (out_valid) chk($sformatf("bp.extra_out%0d", n), 32'(out_valid), 32'd0);
    end

    // Reset mid-flight: three beats in the pipe, one reset edge, none may appear.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      A        = 32'(100 + i);
      B        = 32'd0;
      Cin      = 1'b0;
      sub      = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    chk("mid_rst.out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst.sum",       Sum,            32'd0);
    chk("mid_rst.zero",      32'(Zero),      32'd0);
    rst_n = 1'b1;
    tick();
    chk("mid_rst.in_ready", 32'(in_ready), 32'd1);
    for (int n = 0; n < 8; n++) begin
      if (out_valid) chk($sformatf("mid_rst.ghost%0d", n), Sum, 32'hDEAD_0000);
      tick();
    end
    chk("mid_rst.quiet", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
